// File: rtl/shift_sequencer_pkg.sv
// Shared encodings for the multi-cycle shift sequencer and its single-step shifter.
package shift_sequencer_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_AMT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Mode is {arithmetic, direction}; direction 1 means right.
  typedef enum logic [1:0] {
    LSL = 2'b00,
    LSR = 2'b01,
    ASL = 2'b10,
    ASR = 2'b11
  } mode_t;

endpackage

// File: rtl/barrelShifter.sv
// Existing 8-bit single-position shifter, used as a purely combinational step unit.
module barrelShifter
  import shift_sequencer_pkg::*;
(
  input  logic [7:0] dataIn,
  input  mode_t      mode,
  output logic [7:0] dataOut,
  output logic       Carry
);

  // One-position shift selected by mode
  always_comb begin
    dataOut = dataIn;
    Carry   = 1'b0;
    case (mode)
      LSL, ASL: begin
        dataOut = {dataIn[6:0], 1'b0};
        Carry   = dataIn[7];
      end
      LSR: begin
        dataOut = {1'b0, dataIn[7:1]};
        Carry   = dataIn[0];
      end
      ASR: begin
        dataOut = {dataIn[7], dataIn[7:1]};
        Carry   = dataIn[0];
      end
      default: begin
        dataOut = dataIn;
        Carry   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle N-position shift built from repeated passes through the single-step shifter.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AMT_W = DEF_AMT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dataIn,
  input  logic [AMT_W-1:0] amount,
  input  logic             direction,
  input  logic             arithmetic,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carryOut
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             state_r;
  mode_t              mode_r;
  logic [WIDTH-1:0]   work_r;
  logic [CNT_W-1:0]   count_r;
  logic               busy_r;
  logic               done_r;
  logic               carry_r;
  logic [CNT_W-1:0]   clamp_s;
  logic [WIDTH-1:0]   step_out_s;
  logic               step_carry_unused_s;
  logic               shift_out_s;

  barrelShifter u_step (
    .dataIn  (work_r),
    .mode    (mode_r),
    .dataOut (step_out_s),
    .Carry   (step_carry_unused_s)
  );

  // Pass count saturates at WIDTH; beyond that every bit has already left the operand
  always_comb begin
    if (int'(amount) >= WIDTH) begin
      clamp_s = CNT_W'(WIDTH);
    end else begin
      clamp_s = CNT_W'(amount);
    end
  end

  // Bit leaving the operand on this pass, taken from the pre-step value
  always_comb begin
    if (mode_r[0]) begin
      shift_out_s = work_r[0];
    end else begin
      shift_out_s = work_r[WIDTH-1];
    end
  end

  // Control FSM, pass counter and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      mode_r  <= LSL;
      work_r  <= '0;
      count_r <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      carry_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            work_r  <= dataIn;
            mode_r  <= mode_t'({arithmetic, direction});
            count_r <= clamp_s;
            carry_r <= 1'b0;
            busy_r  <= 1'b1;
            if (clamp_s != CNT_W'(0)) begin
              state_r <= SHIFT;
            end else begin
              state_r <= DONE;
              done_r  <= 1'b1;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          work_r  <= step_out_s;
          carry_r <= shift_out_s;
          count_r <= count_r - CNT_W'(1);
          if (count_r == CNT_W'(1)) begin
            state_r <= DONE;
            done_r  <= 1'b1;
          end else begin
            state_r <= SHIFT;
          end
        end
        DONE: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign result   = work_r;
  assign carryOut = carry_r;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed and randomized checks of shift_sequencer against an arithmetic reference model.
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] dataIn;
  logic [3:0] amount;
  logic       direction;
  logic       arithmetic;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       carryOut;

  int checks = 0;
  int failures = 0;

  shift_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .dataIn     (dataIn),
    .amount     (amount),
    .direction  (direction),
    .arithmetic (arithmetic),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .carryOut   (carryOut)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: whole N-position shift computed directly with integer arithmetic.
  task automatic model(input logic [7:0] d, input logic [3:0] amt, input logic ar,
                       input logic dr, output logic [7:0] r, output logic c, output int n);
    int v;
    v = int'(d);
    n = (int'(amt) >= 8) ? 8 : int'(amt);
    if (n == 0) begin
      r = d;
      c = 1'b0;
    end else if (!dr) begin
      r = 8'((v << n) & 255);
      c = 1'((v >> (8 - n)) & 1);
    end else begin
      r = 8'(v >> n);
      if (ar && d[7]) r = r | 8'((255 << (8 - n)) & 255);
      c = 1'((v >> (n - 1)) & 1);
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] d, input logic [3:0] amt,
                        input logic ar, input logic dr, input logic noise);
    logic [7:0] er;
    logic       ec;
    int         n;
    model(d, amt, ar, dr, er, ec, n);
    dataIn = d; amount = amt; arithmetic = ar; direction = dr; start = 1'b1;
    tick;
    start = 1'b0;
    dataIn = 8'($urandom); amount = 4'($urandom);
    arithmetic = 1'($urandom); direction = 1'($urandom);
    for (int j = 0; j <= n + 2; j++) begin
      chk({tag, " busy"}, 8'(busy), 8'(j <= n));
      chk({tag, " done"}, 8'(done), 8'(j == n));
      if (j == n) begin
        chk({tag, " result"}, result, er);
        chk({tag, " carry"}, 8'(carryOut), 8'(ec));
      end
      if (noise && j <= n) begin
        start = 1'b1;
        dataIn = 8'($urandom); amount = 4'($urandom);
        arithmetic = 1'($urandom); direction = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      tick;
    end
    chk({tag, " result held"}, result, er);
    chk({tag, " carry held"}, 8'(carryOut), 8'(ec));
  endtask

  initial begin
    reset = 1'b1; start = 1'b1; dataIn = 8'hAA; amount = 4'd3;
    direction = 1'b0; arithmetic = 1'b0;
    tick;
    tick;
    chk("reset result", result, 8'h00);
    chk("reset carry", 8'(carryOut), 8'h00);
    chk("reset busy", 8'(busy), 8'h00);
    chk("reset done", 8'(done), 8'h00);
    reset = 1'b0; start = 1'b0;
    tick;
    chk("idle result", result, 8'h00);
    chk("idle busy", 8'(busy), 8'h00);

    run_op("lsl3", 8'hB4, 4'd3, 1'b0, 1'b0, 1'b0);
    run_op("lsr2", 8'hB4, 4'd2, 1'b0, 1'b1, 1'b0);
    run_op("asr3", 8'hB4, 4'd3, 1'b1, 1'b1, 1'b0);
    run_op("amt0", 8'hB4, 4'd0, 1'b1, 1'b1, 1'b0);
    run_op("asr12", 8'hB4, 4'd12, 1'b1, 1'b1, 1'b0);
    run_op("lsr12", 8'hB4, 4'd12, 1'b0, 1'b1, 1'b0);
    run_op("lsl5 busy-start", 8'hB4, 4'd5, 1'b0, 1'b0, 1'b1);

    // Abort an operation with reset part-way through.
    dataIn = 8'hB4; amount = 4'd5; arithmetic = 1'b0; direction = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("abort busy", 8'(busy), 8'h00);
    chk("abort done", 8'(done), 8'h00);
    chk("abort result", result, 8'h00);
    chk("abort carry", 8'(carryOut), 8'h00);
    for (int k = 0; k < 8; k++) begin
      tick;
      chk("abort no done", 8'(done), 8'h00);
      chk("abort idle", 8'(busy), 8'h00);
    end

    for (int i = 0; i < 40; i++) begin
      run_op("random", 8'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
